// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multicycle MIPS core
package mips_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply or restoring divide iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   div_shift;
    logic [WIDTH:0]       div_trial;

    assign mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    assign div_shift = {acc_i[2*WIDTH-2:0], 1'b0};
    // Bit shifted out of the remainder is kept as the trial's top bit.
    assign div_trial = {acc_i[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd_i};

    always_comb begin
        acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (!div_trial[WIDTH]) begin
                acc_o = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = div_shift;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multicycle MULT/MULTU/DIV/DIVU engine with HI/LO registers
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              WrHi,
    input  logic              WrLo,
    input  logic [WIDTH-1:0]  WrData,
    output logic              Busy,
    output logic              Done,
    output logic              DivZero,
    output logic [WIDTH-1:0]  Hi,
    output logic [WIDTH-1:0]  Lo
);

    muldiv_state_t         state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]      opnd_q, opnd_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dz_q, dz_d;

    muldiv_op_t            op;
    logic                  op_signed, op_div;
    logic                  a_neg, b_neg;
    logic [WIDTH-1:0]      a_mag, b_mag;
    logic [2*WIDTH-1:0]    step_acc;
    logic [2*WIDTH-1:0]    prod_neg;

    assign op        = muldiv_op_t'(Op);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg     = op_signed & A[WIDTH-1];
    assign b_neg     = op_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? (~A + 1'b1) : A;
    assign b_mag     = b_neg ? (~B + 1'b1) : B;
    assign prod_neg  = ~acc_q + 1'b1;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            MD_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? ~acc_q[WIDTH-1:0] + 1'b1 : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? ~acc_q[2*WIDTH-1:WIDTH] + 1'b1 : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end
                state_d = MD_DONE;
            end
            default: begin
                // IDLE and DONE both accept register writes and a new Start.
                if (WrHi) hi_d = WrData;
                if (WrLo) lo_d = WrData;
                state_d = MD_IDLE;
                if (Start) begin
                    is_div_d  = op_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                    opnd_d    = op_div ? b_mag : a_mag;
                    dz_d      = op_div && (B == '0);
                    state_d   = (op_div && (B == '0)) ? MD_DONE : MD_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign Busy    = (state_q == MD_RUN) || (state_q == MD_FIX);
    assign Done    = (state_q == MD_DONE);
    assign DivZero = (state_q == MD_DONE) && dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        WrHi = 1'b0;
    logic        WrLo = 1'b0;
    logic [31:0] WrData = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    bit busy_seen;
    bit done_seen;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .WrHi    (WrHi),
        .WrLo    (WrLo),
        .WrData  (WrData),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start is raised at a falling edge; cyc counts rising edges until Done is seen.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int cycles, output bit bsy);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        cycles = 0;
        bsy = 1'b0;
        do begin
            @(negedge Clk);
            cycles++;
            Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
            bsy = bsy | Busy;
            if (disturb && cycles == 5) begin
                Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd3;
                WrHi = 1'b1; WrLo = 1'b1; WrData = 32'hDEAD;
            end
        end while (!Done && cycles < 100);
        Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
        if (!Done) check("done_timeout", 64'(Done), 64'd1);
    endtask

    task automatic write_hilo(input bit hi, input bit lo, input logic [31:0] d);
        @(negedge Clk);
        WrHi = hi; WrLo = lo; WrData = d;
        @(negedge Clk);
        WrHi = 1'b0; WrLo = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dz", 64'(DivZero), 64'd0);
        check("rst_hilo", {Hi, Lo}, 64'd0);
        Reset = 1'b1;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, busy_seen);
        check("multu_lat", 64'(cyc), 64'd34);
        check("multu_hilo", {Hi, Lo}, 64'hFFFFFFFE_00000001);
        check("multu_dz", 64'(DivZero), 64'd0);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, cyc, busy_seen);
        check("mult_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
        check("mult_dz", 64'(DivZero), 64'd0);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, busy_seen);
        check("div_neg_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(2'b11, 32'h80000000, 32'd3, 1'b0, cyc, busy_seen);
        check("divu_hilo", {Hi, Lo}, 64'h00000002_2AAAAAAA);
        check("divu_lat", 64'(cyc), 64'd34);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, busy_seen);
        check("div_ovf_hilo", {Hi, Lo}, 64'h00000000_80000000);

        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, cyc, busy_seen);
        check("div_negb_hilo", {Hi, Lo}, 64'h00000001_FFFFFFFD);

        write_hilo(1'b1, 1'b1, 32'h55);
        run_op(2'b10, 32'd5, 32'd0, 1'b0, cyc, busy_seen);
        check("dz_lat", 64'(cyc), 64'd1);
        check("dz_done", 64'(Done), 64'd1);
        check("dz_flag", 64'(DivZero), 64'd1);
        check("dz_hilo", {Hi, Lo}, 64'h00000055_00000055);
        check("dz_busy", 64'(busy_seen), 64'd0);
        @(negedge Clk);
        check("dz_done_pulse", 64'(Done), 64'd0);

        @(negedge Clk);
        Start = 1'b1; Op = 2'b00; A = 32'd123; B = 32'd456;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        check("abort_busy_pre", 64'(Busy), 64'd1);
        Reset = 1'b0;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            done_seen = done_seen | Done | Busy;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        run_op(2'b00, 32'd6, 32'hFFFFFFFE, 1'b0, cyc, busy_seen);
        check("after_abort_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF4);
        check("after_abort_lat", 64'(cyc), 64'd34);

        write_hilo(1'b1, 1'b0, 32'h1234);
        check("mthi", 64'(Hi), 64'h1234);
        run_op(2'b11, 32'd100, 32'd7, 1'b1, cyc, busy_seen);
        check("busy_ign_lat", 64'(cyc), 64'd34);
        check("busy_ign_hilo", {Hi, Lo}, 64'h00000002_0000000E);
        @(negedge Clk);
        check("busy_ign_idle", 64'({Busy, Done}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
